regfile_read_arbiter: RTL

//   Shares the single 32:1 register-file read multiplexer among N_REQ requesters.

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 42 ++++
 rtl/regfile_read_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file read arbiter.
package regfile_arb_pkg;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  localparam int N_REQ_DEFAULT     = 4;
  localparam int BUS_WIDTH_DEFAULT = 32;
  localparam int SEL_DEFAULT       = 5;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any_req
);

  logic [IW-1:0] cand_idx [N_REQ];

  // Candidate at offset gi from ptr; explicit wrap so non-power-of-2 counts work.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                    : sum[IW-1:0];
    end
  endgenerate

  // Scan from the far end so the nearest candidate is the last to overwrite.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    onehot  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        idx     = cand_idx[k];
        any_req = 1'b1;
      end
    end
    if (any_req) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among N_REQ clients.
// Optional feature macro: REGFILE_ARB_ZERO_REG_EN (address 0 answered in one cycle as zero).
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT,
  parameter int SEL       = SEL_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N_REQ-1:0]     Req,
  input  logic [N_REQ*SEL-1:0] Addr,
  output logic [N_REQ-1:0]     Grant,
  output logic [N_REQ-1:0]     Valid,
  output logic [BUS_WIDTH-1:0] Rdata,
  output logic [SEL-1:0]       Mux_Sel,
  input  logic [BUS_WIDTH-1:0] Mux_Dout
);

  localparam int IW = idx_width(N_REQ);

  state_t               state_reg, state_next;
  logic [IW-1:0]        ptr_reg, ptr_next;
  logic [IW-1:0]        win_reg, win_next;
  logic [SEL-1:0]       sel_reg, sel_next;
  logic [BUS_WIDTH-1:0] rdata_reg, rdata_next;
  logic [N_REQ-1:0]     grant_reg, grant_next;
  logic [N_REQ-1:0]     valid_reg, valid_next;

  logic [N_REQ-1:0]     pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [IW-1:0]        pick_inc, win_inc;
  logic                 zero_hit;
  logic [SEL-1:0]       addr_slot [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_slot[gi] = Addr[gi*SEL +: SEL];
    end
  endgenerate

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req     (Req),
    .ptr     (ptr_reg),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign pick_inc = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
  assign win_inc  = (win_reg  == IW'(N_REQ - 1)) ? '0 : win_reg  + IW'(1);

`ifdef REGFILE_ARB_ZERO_REG_EN
  assign zero_hit = (addr_slot[pick_idx] == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    sel_next   = sel_reg;
    rdata_next = rdata_reg;
    grant_next = '0;
    valid_next = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          win_next   = pick_idx;
          grant_next = pick_onehot;
          if (zero_hit) begin
            // Register 0 reads as zero: finish now, leave the mux select alone.
            valid_next = pick_onehot;
            rdata_next = '0;
            ptr_next   = pick_inc;
          end else begin
            sel_next   = addr_slot[pick_idx];
            state_next = READ;
          end
        end
      end
      READ: begin
        rdata_next          = Mux_Dout;
        valid_next[win_reg] = 1'b1;
        ptr_next            = win_inc;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      sel_reg   <= '0;
      rdata_reg <= '0;
      grant_reg <= '0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      sel_reg   <= sel_next;
      rdata_reg <= rdata_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
    end
  end

  assign Grant   = grant_reg;
  assign Valid   = valid_reg;
  assign Rdata   = rdata_reg;
  assign Mux_Sel = sel_reg;

endmodule
